// File: rtl/sdram_arbiter_mc.sv
// Multi-channel SDRAM command arbiter: init hold-off, refresh priority, round-robin channel grant, pin mux.
// Optional watchdog on AREF/ACCESS enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_arbiter_mc #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 12,
  parameter int BANK_W   = 2,
  parameter int DQ_W     = 16,
  parameter int WDOG_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_done,
  input  logic [3:0]               init_cmd,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic                     ref_req,
  output logic                     ref_en,
  input  logic                     ref_end,
  input  logic [3:0]               ref_cmd,
  input  logic [ADDR_W-1:0]        ref_addr,
  output logic                     ref_pending,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_end,
  input  logic [4*NUM_CH-1:0]      ch_cmd,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [BANK_W*NUM_CH-1:0] ch_bank,
  input  logic [DQ_W*NUM_CH-1:0]   ch_wdata,
  input  logic [NUM_CH-1:0]        ch_dq_oe,
  output logic [3:0]               sdram_cmd,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [BANK_W-1:0]        sdram_bank,
  output logic [DQ_W-1:0]          sdram_dq_out,
  output logic                     sdram_dq_oe,
  output logic [2:0]               grant_id,
  output logic                     err_timeout
);

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_ARBIT  = 4'b0010;
  localparam logic [3:0] S_AREF   = 4'b0100;
  localparam logic [3:0] S_ACCESS = 4'b1000;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  logic [3:0] state;
  logic [2:0] rr_ptr;
  logic       arb_found;
  logic [2:0] arb_g;
  logic [2:0] arb_next_ptr;
  logic [3:0] idx;
  logic       cur_end;
  logic       op_end;
  logic       wdog_hit;

  // Round-robin search starting at rr_ptr, wrapping without a modulo divider.
  always_comb begin
    arb_found    = 1'b0;
    arb_g        = 3'd0;
    arb_next_ptr = 3'd0;
    idx          = 4'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_CH))
        idx = idx - 4'(NUM_CH);
      if (!arb_found && ch_req[idx[2:0]]) begin
        arb_found = 1'b1;
        arb_g     = idx[2:0];
      end
    end
    if (arb_g == 3'(NUM_CH - 1))
      arb_next_ptr = 3'd0;
    else
      arb_next_ptr = arb_g + 3'd1;
  end

  always_comb begin
    cur_end = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant_id == 3'(i))
        cur_end = ch_end[i];
  end

  assign op_end = (state == S_AREF) ? ref_end : cur_end;

`ifdef SDRAM_ARB_WDOG_EN
  logic [15:0] wdog_cnt;

  assign wdog_hit = (wdog_cnt == 16'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt    <= 16'd0;
      err_timeout <= 1'b0;
    end else if (state == S_AREF || state == S_ACCESS) begin
      wdog_cnt <= wdog_cnt + 16'd1;
      if (wdog_hit && !op_end)
        err_timeout <= 1'b1;
    end else begin
      wdog_cnt <= 16'd0;
    end
  end
`else
  assign wdog_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ref_en      <= 1'b0;
      ch_en       <= '0;
      grant_id    <= 3'd0;
      rr_ptr      <= 3'd0;
      ref_pending <= 1'b0;
    end else begin
      ref_en <= 1'b0;
      ch_en  <= '0;
      // A new request arriving during the grant cycle survives the clear.
      if (ref_req)
        ref_pending <= 1'b1;
      else if (ref_en)
        ref_pending <= 1'b0;
      case (state)
        S_IDLE: if (init_done) state <= S_ARBIT;
        S_ARBIT: begin
          if (ref_pending || ref_req) begin
            ref_en <= 1'b1;
            state  <= S_AREF;
          end else if (arb_found) begin
            ch_en    <= NUM_CH'(1) << arb_g;
            grant_id <= arb_g;
            rr_ptr   <= arb_next_ptr;
            state    <= S_ACCESS;
          end
        end
        S_AREF: begin
          if (op_end)
            state <= S_ARBIT;
          else if (wdog_hit) begin
            state       <= S_ARBIT;
            ref_pending <= 1'b1;
          end
        end
        S_ACCESS: if (op_end || wdog_hit) state <= S_ARBIT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    case (state)
      S_IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_ACCESS: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (grant_id == 3'(i)) begin
            sdram_cmd    = ch_cmd[4*i +: 4];
            sdram_addr   = ch_addr[ADDR_W*i +: ADDR_W];
            sdram_bank   = ch_bank[BANK_W*i +: BANK_W];
            sdram_dq_out = ch_wdata[DQ_W*i +: DQ_W];
            sdram_dq_oe  = ch_dq_oe[i];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter_mc.sv
// Directed self-checking bench for sdram_arbiter_mc with three channels.
module tb_sdram_arbiter_mc;

  localparam int NUM_CH   = 3;
  localparam int ADDR_W   = 12;
  localparam int BANK_W   = 2;
  localparam int DQ_W     = 16;
  localparam int WDOG_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     init_done;
  logic [3:0]               init_cmd;
  logic [ADDR_W-1:0]        init_addr;
  logic                     ref_req;
  logic                     ref_en;
  logic                     ref_end;
  logic [3:0]               ref_cmd;
  logic [ADDR_W-1:0]        ref_addr;
  logic                     ref_pending;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        ch_end;
  logic [4*NUM_CH-1:0]      ch_cmd;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [BANK_W*NUM_CH-1:0] ch_bank;
  logic [DQ_W*NUM_CH-1:0]   ch_wdata;
  logic [NUM_CH-1:0]        ch_dq_oe;
  logic [3:0]               sdram_cmd;
  logic [ADDR_W-1:0]        sdram_addr;
  logic [BANK_W-1:0]        sdram_bank;
  logic [DQ_W-1:0]          sdram_dq_out;
  logic                     sdram_dq_oe;
  logic [2:0]               grant_id;
  logic                     err_timeout;

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0]        exp_cmd  [NUM_CH] = '{4'b0011, 4'b0101, 4'b0100};
  logic [ADDR_W-1:0] exp_addr [NUM_CH] = '{12'h0AA, 12'h111, 12'h222};
  logic [BANK_W-1:0] exp_bank [NUM_CH] = '{2'd1, 2'd2, 2'd3};

  localparam logic [3:0]        INIT_CMD  = 4'b0010;
  localparam logic [ADDR_W-1:0] INIT_ADDR = 12'h400;
  localparam logic [3:0]        REF_CMD   = 4'b0001;
  localparam logic [ADDR_W-1:0] REF_ADDR  = 12'h3FF;
  localparam logic [3:0]        NOP       = 4'b0111;

  sdram_arbiter_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .ref_pending(ref_pending), .ch_req(ch_req), .ch_en(ch_en), .ch_end(ch_end), .ch_cmd(ch_cmd),
    .ch_addr(ch_addr), .ch_bank(ch_bank), .ch_wdata(ch_wdata), .ch_dq_oe(ch_dq_oe),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .grant_id(grant_id),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance a number of clock edges; inputs set before the call are sampled by the first edge.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    int g;
    rst       = 1'b1;
    init_done = 1'b0;
    init_cmd  = INIT_CMD;
    init_addr = INIT_ADDR;
    ref_req   = 1'b0;
    ref_end   = 1'b0;
    ref_cmd   = REF_CMD;
    ref_addr  = REF_ADDR;
    ch_req    = '0;
    ch_end    = '0;
    ch_cmd    = {exp_cmd[2], exp_cmd[1], exp_cmd[0]};
    ch_addr   = {exp_addr[2], exp_addr[1], exp_addr[0]};
    ch_bank   = {exp_bank[2], exp_bank[1], exp_bank[0]};
    ch_wdata  = {16'h2222, 16'h1111, 16'hA5A5};
    ch_dq_oe  = '0;

    applyStimulus(2);
    checkOutput("rst_ch_en", 32'(ch_en), 32'(0));
    checkOutput("rst_ref_en", 32'(ref_en), 32'(0));
    checkOutput("rst_grant_id", 32'(grant_id), 32'(0));
    checkOutput("rst_ref_pending", 32'(ref_pending), 32'(0));
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'(0));
    checkOutput("rst_cmd", 32'(sdram_cmd), 32'(INIT_CMD));
    checkOutput("rst_addr", 32'(sdram_addr), 32'(INIT_ADDR));

    // Channels request during init; nothing may be granted.
    rst    = 1'b0;
    ch_req = 3'b111;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1);
      checkOutput("init_cmd", 32'(sdram_cmd), 32'(INIT_CMD));
      checkOutput("init_ch_en", 32'(ch_en), 32'(0));
    end

    init_done = 1'b1;
    ch_req    = '0;
    applyStimulus(1);
    checkOutput("arbit_nop", 32'(sdram_cmd), 32'(NOP));
    checkOutput("arbit_addr", 32'(sdram_addr), 32'(0));
    checkOutput("arbit_dq_oe", 32'(sdram_dq_oe), 32'(0));
    applyStimulus(1);
    checkOutput("no_req_no_grant", 32'(ch_en), 32'(0));

    // Round-robin: all three request, each ends 4 cycles after its grant.
    ch_req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      g = n % 3;
      applyStimulus(1);
      checkOutput("rr_ch_en", 32'(ch_en), 32'(1) << g);
      checkOutput("rr_grant_id", 32'(grant_id), 32'(g));
      checkOutput("rr_cmd", 32'(sdram_cmd), 32'(exp_cmd[g]));
      checkOutput("rr_addr", 32'(sdram_addr), 32'(exp_addr[g]));
      checkOutput("rr_bank", 32'(sdram_bank), 32'(exp_bank[g]));
      ch_end = 3'b001 << ((g + 1) % 3);
      applyStimulus(1);
      ch_end = '0;
      checkOutput("rr_foreign_end", 32'(sdram_cmd), 32'(exp_cmd[g]));
      checkOutput("rr_one_cycle", 32'(ch_en), 32'(0));
      applyStimulus(3);
      ch_end = 3'b001 << g;
      if (n == 5) ch_req = '0;
      applyStimulus(1);
      ch_end = '0;
      checkOutput("rr_nop_gap", 32'(sdram_cmd), 32'(NOP));
      checkOutput("rr_gap_no_grant", 32'(ch_en), 32'(0));
    end

    // Refresh request arrives while ch1 owns the bus.
    ch_req = 3'b010;
    applyStimulus(1);
    checkOutput("ref1_grant_ch1", 32'(ch_en), 32'(3'b010));
    ch_req  = '0;
    ref_req = 1'b1;
    applyStimulus(1);
    ref_req = 1'b0;
    checkOutput("ref1_pending", 32'(ref_pending), 32'(1));
    checkOutput("ref1_no_ref_en", 32'(ref_en), 32'(0));
    applyStimulus(2);
    checkOutput("ref1_pending_held", 32'(ref_pending), 32'(1));
    checkOutput("ref1_still_ch1", 32'(sdram_cmd), 32'(exp_cmd[1]));
    ch_req = 3'b001;
    ch_end = 3'b010;
    applyStimulus(1);
    ch_end = '0;
    checkOutput("ref1_gap", 32'(sdram_cmd), 32'(NOP));
    checkOutput("ref1_pending_gap", 32'(ref_pending), 32'(1));
    applyStimulus(1);
    checkOutput("ref1_ref_en", 32'(ref_en), 32'(1));
    checkOutput("ref1_ch_blocked", 32'(ch_en), 32'(0));
    checkOutput("ref1_ref_cmd", 32'(sdram_cmd), 32'(REF_CMD));
    checkOutput("ref1_ref_addr", 32'(sdram_addr), 32'(REF_ADDR));
    applyStimulus(1);
    checkOutput("ref1_pending_clr", 32'(ref_pending), 32'(0));
    checkOutput("ref1_ref_en_pulse", 32'(ref_en), 32'(0));
    ref_end = 1'b1;
    applyStimulus(1);
    ref_end = 1'b0;
    checkOutput("ref1_back_arbit", 32'(sdram_cmd), 32'(NOP));
    applyStimulus(1);
    checkOutput("ref1_ch0_after", 32'(ch_en), 32'(3'b001));
    ch_req = '0;
    ch_end = 3'b001;
    applyStimulus(1);
    ch_end = '0;

    // Refresh and ch0 requested in the same arbitration cycle; ch0 writes afterwards.
    ref_req  = 1'b1;
    ch_req   = 3'b001;
    ch_dq_oe = 3'b001;
    applyStimulus(1);
    ref_req = 1'b0;
    checkOutput("ref2_ref_en", 32'(ref_en), 32'(1));
    checkOutput("ref2_ch_en", 32'(ch_en), 32'(0));
    applyStimulus(1);
    checkOutput("ref2_pending_clr", 32'(ref_pending), 32'(0));
    ref_end = 1'b1;
    applyStimulus(1);
    ref_end = 1'b0;
    checkOutput("ref2_gap", 32'(ch_en), 32'(0));
    checkOutput("ref2_gap_dq_oe", 32'(sdram_dq_oe), 32'(0));
    applyStimulus(1);
    checkOutput("ref2_ch0_grant", 32'(ch_en), 32'(3'b001));
    checkOutput("wr_dq_oe", 32'(sdram_dq_oe), 32'(1));
    checkOutput("wr_dq_out", 32'(sdram_dq_out), 32'(16'hA5A5));
    ch_req = '0;
    ch_end = 3'b001;
    applyStimulus(1);
    ch_end = '0;
    checkOutput("wr_arbit_dq_oe", 32'(sdram_dq_oe), 32'(0));
    checkOutput("wr_arbit_dq_out", 32'(sdram_dq_out), 32'(0));
    ch_dq_oe = '0;

    // A new ref_req in the ref_en cycle must leave refresh pending.
    ref_req = 1'b1;
    applyStimulus(1);
    checkOutput("setwin_ref_en", 32'(ref_en), 32'(1));
    applyStimulus(1);
    ref_req = 1'b0;
    checkOutput("setwin_pending", 32'(ref_pending), 32'(1));
    ref_end = 1'b1;
    applyStimulus(1);
    ref_end = 1'b0;
    applyStimulus(1);
    checkOutput("setwin_second_ref", 32'(ref_en), 32'(1));
    ref_end = 1'b1;
    applyStimulus(1);
    ref_end = 1'b0;

    // Round-robin pointer sits at ch1, so a ch2-only request wins; then reset mid-access.
    ch_req = 3'b100;
    applyStimulus(1);
    checkOutput("rst_mid_grant", 32'(grant_id), 32'(2));
    ch_req = '0;
`ifdef SDRAM_ARB_WDOG_EN
    applyStimulus(WDOG_CYC - 1);
    checkOutput("wdog_still_access", 32'(sdram_cmd), 32'(exp_cmd[2]));
    checkOutput("wdog_no_err_yet", 32'(err_timeout), 32'(0));
    applyStimulus(1);
    checkOutput("wdog_forced_arbit", 32'(sdram_cmd), 32'(NOP));
    checkOutput("wdog_err", 32'(err_timeout), 32'(1));
    applyStimulus(5);
    checkOutput("wdog_err_sticky", 32'(err_timeout), 32'(1));
    ch_req = 3'b001;
    applyStimulus(1);
    ch_req = '0;
`endif
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst_mid_cmd", 32'(sdram_cmd), 32'(INIT_CMD));
    checkOutput("rst_mid_ch_en", 32'(ch_en), 32'(0));
    checkOutput("rst_mid_grant_id", 32'(grant_id), 32'(0));
    checkOutput("rst_mid_err", 32'(err_timeout), 32'(0));
    applyStimulus(1);
    checkOutput("rst_mid_rearbit", 32'(sdram_cmd), 32'(NOP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
